aes_block_serdes: RTL and testbench
===================================

Name: aes_block_serdes

Overview:
- Block-level framing stage around the byte-serial AES core. Accepts one 128-bit block plus mode over a valid/ready handshake and pulses the core's start.
- Streams the 16 input bytes into the core's 8-bit data input, then captures the 16 result bytes that follow the core's z_ready pulse.
- Presents the reassembled 128-bit result on a valid/ready output.
- Sits directly between the system bus side and the core's data/start/mode/z/z_ready pins.

Parameters:
- FEED_DELAY, 1: cycles from the core_start cycle to the cycle carrying byte 0 on core_data.
- CAPTURE_OFFSET, 0: cycles from the cycle core_z_ready is sampled high to the cycle byte 0 of the result is sampled.
- CORE_CYCLES, 180: minimum cycles from core_start to the next permitted core_start; this is the core run length.
- TIMEOUT, 255: maximum cycles from core_start to core_z_ready before an error is flagged. Used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-low reset.
- in_valid  in  1  input block offered.
- in_ready  out  1  block accepted when in_valid and in_ready are both high.
- in_block  in  128  plaintext or ciphertext; byte 0 = [127:120].
- in_mode  in  1  0 = encrypt, 1 = decrypt.
- core_start  out  1  one-cycle start pulse to the core.
- core_data  out  8  byte stream to the core.
- core_mode  out  1  latched mode; held stable for the whole operation.
- core_z  in  8  result byte stream from the core.
- core_z_ready  in  1  result-start marker from the core.
- out_valid  out  1  result block valid.
- out_ready  in  1  consumer accepts the result.
- out_block  out  128  result; byte 0 = [127:120].
- out_mode  out  1  mode the result was produced with.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst == 0 at a clk edge) sets:
  - state = IDLE;
  - in_ready = 1;
  - core_start = 0, core_data = 0, core_mode = 0;
  - out_valid = 0, out_block = 0, out_mode = 0;
  - busy = 0; all counters = 0.
  - Reset mid-operation abandons the block and discards partial capture; no output is produced for it.
- Input handshake:
  - in_ready = 1 only in IDLE.
  - On acceptance, latch in_block and in_mode. Go to FEED, and assert core_start for exactly that following cycle (cycle S).
- FEED:
  - core_data = byte k in cycle S+FEED_DELAY+k, for k = 0..15.
  - core_data = 0 in all other cycles.
  - After byte 15 has been driven, go to WAIT.
- WAIT:
  - On core_z_ready sampled high at cycle R, go to CAPTURE.
  - A core_z_ready seen during FEED is ignored.
- CAPTURE:
  - Sample core_z at cycles R+CAPTURE_OFFSET+k for k = 0..15.
  - Byte k goes to out_block[127-8k -: 8].
  - After byte 15, set out_valid = 1 and out_mode = latched mode; go to HOLD.
- HOLD:
  - out_block and out_valid stay stable until out_valid && out_ready.
  - Then out_valid = 0 on the next cycle; go to DRAIN.
  - out_ready already high when out_valid rises gives a one-cycle valid.
- DRAIN:
  - Wait until a free-running op counter (cleared at S) reaches CORE_CYCLES-1, then go to IDLE.
  - If the counter has already passed that value, go to IDLE the next cycle.
  - Guarantees core_start pulses are at least CORE_CYCLES apart.
- Op counter width is ceil(log2(max(CORE_CYCLES, TIMEOUT)+1)) and saturates; no wrap.
- core_mode is updated only on input acceptance; it never changes while busy.
- in_valid during busy is held off (in_ready = 0); no data loss.

Optional Feature:
- Macro: AES_SERDES_TIMEOUT_EN.
- With the macro defined:
  - Adds output port err (1 bit, reset 0).
  - If WAIT has not seen core_z_ready by op counter == TIMEOUT: err pulses high for one cycle, out_valid stays 0, state goes to DRAIN.
- Without the macro: no err port; WAIT waits indefinitely.

Test Plan:
- FIPS-197 encrypt: key 000102..0f, in_block 00112233445566778899aabbccddeeff, mode 0 → out_block 69c4e0d86a7b0430d8cdb78070b4c55a, out_mode 0.
- Decrypt: in_block 69c4e0d86a7b0430d8cdb78070b4c55a, mode 1 → out_block 00112233445566778899aabbccddeeff, out_mode 1.
- Back-to-back: in_valid held high with two blocks → second core_start exactly 180 cycles after the first (CORE_CYCLES default); both results correct.
- Backpressure: out_ready low 50 cycles after out_valid → out_block stable, in_ready 0 throughout, single transfer when out_ready rises.
- Reset mid-FEED at byte 7 → next cycle in_ready 1, out_valid 0, busy 0, core_data 0; a following block completes correctly.
- With AES_SERDES_TIMEOUT_EN and core_z_ready tied low: err pulses at op counter 255, no out_valid, in_ready returns to 1 at counter 255+1.

Source files
------------

// File: rtl/aes_block_serdes.sv
// Block framing stage around the byte-serial AES core: 128-bit valid/ready in, byte feed/capture, 128-bit valid/ready out.
// Optional macro AES_SERDES_TIMEOUT_EN adds an err output that fires when the core never raises core_z_ready.
module aes_block_serdes #(
    parameter int FEED_DELAY     = 1,
    parameter int CAPTURE_OFFSET = 0,
    parameter int CORE_CYCLES    = 180,
    parameter int TIMEOUT        = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    input  logic         in_mode,
    output logic         core_start,
    output logic [7:0]   core_data,
    output logic         core_mode,
    input  logic [7:0]   core_z,
    input  logic         core_z_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         out_mode,
    output logic         busy
`ifdef AES_SERDES_TIMEOUT_EN
    ,
    output logic         err
`endif
);

    localparam int CNT_MAX = (CORE_CYCLES > TIMEOUT) ? CORE_CYCLES : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int OFF_W   = (CAPTURE_OFFSET > 1) ? $clog2(CAPTURE_OFFSET) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FEED    = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_HOLD    = 3'd4,
        S_DRAIN   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   op_q, op_d;
    logic [127:0]       blk_q, blk_d;
    logic [4:0]         feed_cnt_q, feed_cnt_d;
    logic [127:0]       cap_sr_q, cap_sr_d;
    logic [3:0]         cap_cnt_q, cap_cnt_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               core_start_q, core_start_d;
    logic [7:0]         core_data_q, core_data_d;
    logic               core_mode_q, core_mode_d;
    logic               out_valid_q, out_valid_d;
    logic [127:0]       out_block_q, out_block_d;
    logic               out_mode_q, out_mode_d;
`ifdef AES_SERDES_TIMEOUT_EN
    logic               err_q, err_d;
`endif

    // Next-state and registered-output logic for the framing FSM.
    always_comb begin
        state_d      = state_q;
        op_d         = (&op_q) ? op_q : op_q + CNT_W'(1);
        blk_d        = blk_q;
        feed_cnt_d   = feed_cnt_q;
        cap_sr_d     = cap_sr_q;
        cap_cnt_d    = cap_cnt_q;
        off_d        = off_q;
        core_start_d = 1'b0;
        core_data_d  = 8'h00;
        core_mode_d  = core_mode_q;
        out_valid_d  = out_valid_q;
        out_block_d  = out_block_q;
        out_mode_d   = out_mode_q;
`ifdef AES_SERDES_TIMEOUT_EN
        err_d        = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d      = S_FEED;
                    op_d         = '0;
                    core_start_d = 1'b1;
                    core_mode_d  = in_mode;
                    if (FEED_DELAY == 0) begin
                        core_data_d = in_block[127:120];
                        blk_d       = {in_block[119:0], 8'h00};
                        feed_cnt_d  = 5'd1;
                    end else begin
                        blk_d       = in_block;
                        feed_cnt_d  = 5'd0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FEED: begin
                // Each byte is registered, so it is emitted one cycle ahead of its slot.
                if (feed_cnt_q == 5'd16) begin
                    state_d = S_WAIT;
                end else if (int'(op_q) + 32'sd1 >= FEED_DELAY) begin
                    core_data_d = blk_q[127:120];
                    blk_d       = {blk_q[119:0], 8'h00};
                    feed_cnt_d  = feed_cnt_q + 5'd1;
                end else begin
                    feed_cnt_d  = feed_cnt_q;
                end
            end
            S_WAIT: begin
                if (core_z_ready) begin
                    state_d   = S_CAPTURE;
                    cap_cnt_d = 4'd0;
                    if (CAPTURE_OFFSET == 0) begin
                        cap_sr_d  = {cap_sr_q[119:0], core_z};
                        cap_cnt_d = 4'd1;
                    end else begin
                        off_d     = OFF_W'(CAPTURE_OFFSET - 1);
                    end
`ifdef AES_SERDES_TIMEOUT_EN
                end else if (int'(op_q) >= TIMEOUT - 1) begin
                    err_d   = 1'b1;
                    state_d = S_DRAIN;
`endif
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_CAPTURE: begin
                if (off_q != '0) begin
                    off_d = off_q - OFF_W'(1);
                end else if (cap_cnt_q == 4'd15) begin
                    out_block_d = {cap_sr_q[119:0], core_z};
                    out_valid_d = 1'b1;
                    out_mode_d  = core_mode_q;
                    state_d     = S_HOLD;
                end else begin
                    cap_sr_d  = {cap_sr_q[119:0], core_z};
                    cap_cnt_d = cap_cnt_q + 4'd1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_DRAIN;
                end else begin
                    state_d     = S_HOLD;
                end
            end
            S_DRAIN: begin
                // Leaving one cycle early puts IDLE at count CORE_CYCLES-1, so the next start lands exactly CORE_CYCLES later.
                if (int'(op_q) >= CORE_CYCLES - 2) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            blk_q        <= '0;
            feed_cnt_q   <= 5'd0;
            cap_sr_q     <= '0;
            cap_cnt_q    <= 4'd0;
            off_q        <= '0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            core_start_q <= 1'b0;
            core_data_q  <= 8'h00;
            core_mode_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_block_q  <= '0;
            out_mode_q   <= 1'b0;
`ifdef AES_SERDES_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            blk_q        <= blk_d;
            feed_cnt_q   <= feed_cnt_d;
            cap_sr_q     <= cap_sr_d;
            cap_cnt_q    <= cap_cnt_d;
            off_q        <= off_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            core_start_q <= core_start_d;
            core_data_q  <= core_data_d;
            core_mode_q  <= core_mode_d;
            out_valid_q  <= out_valid_d;
            out_block_q  <= out_block_d;
            out_mode_q   <= out_mode_d;
`ifdef AES_SERDES_TIMEOUT_EN
            err_q        <= err_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign core_start = core_start_q;
    assign core_data  = core_data_q;
    assign core_mode  = core_mode_q;
    assign out_valid  = out_valid_q;
    assign out_block  = out_block_q;
    assign out_mode   = out_mode_q;
`ifdef AES_SERDES_TIMEOUT_EN
    assign err        = err_q;
`endif

endmodule

// File: tb/tb_aes_block_serdes.sv
// Scoreboard bench for aes_block_serdes with a stand-in byte-serial core model.
`timescale 1ns/1ps
module tb_aes_block_serdes;

    localparam int          CORE_CYCLES = 180;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, in_mode;
    logic [127:0] in_block, out_block;
    logic         core_start, core_mode, core_z_ready;
    logic [7:0]   core_data, core_z;
    logic         out_valid, out_ready, out_mode, busy;
`ifdef AES_SERDES_TIMEOUT_EN
    logic         err;
`endif

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           n_xfer = 0;
    int           ready_mode = 1;
    bit           tb_live = 1'b0;
    bit           gap_exempt = 1'b1;
    bit           mute = 1'b0;
    logic [128:0] exp_q[$];

    aes_block_serdes dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_block(in_block), .in_mode(in_mode), .core_start(core_start),
        .core_data(core_data), .core_mode(core_mode), .core_z(core_z),
        .core_z_ready(core_z_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_block(out_block), .out_mode(out_mode), .busy(busy)
`ifdef AES_SERDES_TIMEOUT_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used for start spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the AES core: FIPS-197 vector pair, otherwise a fixed invertible scramble.
    function automatic logic [127:0] ref_fn(input logic [127:0] b, input logic m);
        if (!m && b == PT) return CT;
        if (m && b == CT) return PT;
        if (m) return {b[63:0], b[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        return ~b ^ 128'h3c3c3c3c3c3c3c3c3c3c3c3c3c3c3c3c;
    endfunction

    task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, req);
        end
    endtask

    task automatic chki(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a block and hold in_valid until accepted; returns in cycle S.
    task automatic send(input logic [127:0] b, input logic m);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_block = b;
        in_mode  = m;
        while (in_ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        chk1("accept_within_bound", (n < 1000), 1'b1);
        exp_q.push_back({m, ref_fn(b, m)});
        tick();
        chk1("core_start_pulse", core_start, 1'b1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_ready !== 1'b1) && n < 2000) begin
            tick();
            n++;
        end
        chk1("drain_within_bound", (n < 2000), 1'b1);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Core model: records fed bytes, checks idle data and mode, then returns the result stream.
    initial begin : core_model
        int c, zr, last_start;
        bit active, spur;
        logic m;
        logic [127:0] rx, res;
        c = 0; zr = 0; last_start = 0; active = 1'b0; spur = 1'b0; m = 1'b0; rx = '0; res = '0;
        core_z = 8'h00;
        core_z_ready = 1'b0;
        forever begin
            tick();
            if (core_start === 1'b1) begin
                if (!gap_exempt)
                    chk1("start_gap_min", (cyc - last_start >= CORE_CYCLES), 1'b1);
                gap_exempt = 1'b0;
                last_start = cyc;
                active = 1'b1;
                c = 0;
                m = core_mode;
                rx = '0;
                zr = 20 + int'($urandom_range(0, 100));
                spur = ($urandom_range(0, 1) == 1);
            end else if (busy !== 1'b1) begin
                active = 1'b0;
            end else if (active) begin
                c++;
            end
            if (tb_live) begin
                if (active && c >= 1 && c <= 16) rx = {rx[119:0], core_data};
                else chk1("core_data_idle_zero", (core_data == 8'h00), 1'b1);
                if (active) chk1("core_mode_stable", core_mode, m);
                if (active && c == 16) res = ref_fn(rx, m);
                if (active && !mute && c >= zr && c < zr + 16) begin
                    core_z_ready = (c == zr);
                    core_z = 8'(res >> (8 * (15 - (c - zr))));
                end else if (active && spur && c == 5) begin
                    core_z_ready = 1'b1;
                    core_z = 8'($urandom);
                end else begin
                    core_z_ready = 1'b0;
                    core_z = 8'($urandom);
                end
            end else begin
                core_z_ready = 1'b0;
                core_z = 8'h00;
            end
        end
    end

    // Consumer: random, always-ready or stalled out_ready.
    initial begin : consumer
        out_ready = 1'b0;
        forever begin
            tick();
            case (ready_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output transfer and checks hold behaviour.
    initial begin : monitor
        logic [128:0] e;
        logic [127:0] held;
        bit was_valid, prev_xfer;
        was_valid = 1'b0; prev_xfer = 1'b0; held = '0;
        forever begin
            @(negedge clk);
            if (tb_live && rst === 1'b1) begin
                chk1("busy_is_not_ready", busy, ~in_ready);
                if (was_valid) begin
                    chk1("valid_held", out_valid, 1'b1);
                    chkw("block_held", out_block, held);
                end
                if (prev_xfer) chk1("valid_drops_after_xfer", out_valid, 1'b0);
                if (out_valid === 1'b1) chk1("in_ready_low_while_valid", in_ready, 1'b0);
                prev_xfer = (out_valid === 1'b1 && out_ready === 1'b1);
                if (prev_xfer) begin
                    n_xfer++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: got %h want none", out_block);
                    end else begin
                        e = exp_q.pop_front();
                        chkw("out_block", out_block, e[127:0]);
                        chk1("out_mode", out_mode, e[128]);
                    end
                end
                was_valid = (out_valid === 1'b1 && out_ready !== 1'b1);
                held = out_block;
            end else begin
                was_valid = 1'b0;
                prev_xfer = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [127:0] b;
        int s1, s2, x0, n;
        rst = 1'b0; in_valid = 1'b0; in_block = '0; in_mode = 1'b0;
        tick();
        tick();
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_core_start", core_start, 1'b0);
        chkw("rst_core_data", 128'(core_data), 128'h0);
        chk1("rst_core_mode", core_mode, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chkw("rst_out_block", out_block, 128'h0);
        chk1("rst_out_mode", out_mode, 1'b0);
`ifdef AES_SERDES_TIMEOUT_EN
        chk1("rst_err", err, 1'b0);
`endif
        rst = 1'b1;
        tb_live = 1'b1;

        // FIPS-197 encrypt then decrypt.
        send(PT, 1'b0);
        in_valid = 1'b0;
        wait_done();
        send(CT, 1'b1);
        in_valid = 1'b0;
        wait_done();

        // Back-to-back with in_valid held high.
        send(rnd128(), 1'b0);
        s1 = cyc;
        send(rnd128(), 1'b1);
        s2 = cyc;
        in_valid = 1'b0;
        chki("back_to_back_gap", s2 - s1, CORE_CYCLES);
        wait_done();

        // Backpressure: stall 50 cycles after out_valid rises.
        ready_mode = 2;
        send(rnd128(), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        chk1("bp_valid_within_bound", (n < 500), 1'b1);
        x0 = n_xfer;
        repeat (50) tick();
        chk1("bp_still_valid", out_valid, 1'b1);
        chki("bp_no_early_xfer", n_xfer - x0, 0);
        ready_mode = 1;
        repeat (6) tick();
        chki("bp_single_xfer", n_xfer - x0, 1);
        wait_done();

        // Reset while byte 7 is on core_data.
        b = rnd128();
        send(b, 1'b0);
        in_valid = 1'b0;
        repeat (8) tick();
        chkw("feed_byte7", 128'(core_data), 128'(b[71:64]));
        gap_exempt = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.delete();
        chk1("midrst_in_ready", in_ready, 1'b1);
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chkw("midrst_core_data", 128'(core_data), 128'h0);
        send(rnd128(), 1'b1);
        in_valid = 1'b0;
        wait_done();

        // Random traffic with random consumer readiness and idle gaps.
        ready_mode = 0;
        for (int i = 0; i < 6; i++) begin
            send(rnd128(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 40)) tick();
            end
        end
        in_valid = 1'b0;
        ready_mode = 1;
        wait_done();

`ifdef AES_SERDES_TIMEOUT_EN
        // Core never answers: err at count TIMEOUT, IDLE one cycle later.
        mute = 1'b1;
        send(rnd128(), 1'b0);
        in_valid = 1'b0;
        exp_q.delete();
        s1 = -1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (err === 1'b1) begin
                s1 = k;
                break;
            end
        end
        chki("timeout_err_cycle", s1, 255);
        tick();
        chk1("timeout_err_one_cycle", err, 1'b0);
        chk1("timeout_in_ready_back", in_ready, 1'b1);
        mute = 1'b0;
        wait_done();
`endif

        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
